rf_read_arbiter: RTL and testbench

Shares the single register-file read port among NREQ requesters, round-robin. The read port is the 32-entry, 32-bit select mux: this block drives its 5-bit select and samples its 32-bit output one cycle later. Returns a registered response tagged one-hot to the winning requester. Also forwards a same-cycle register write and forces register 0 to read as zero.

---
 rtl/rf_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/rf_read_arbiter.sv | 111 +++++++++++
 tb/tb_rf_read_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared sizing constants and a one-hot decode helper for the register-file read arbiter.
package rf_pkg;

  localparam int NREQ_DEF   = 4;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int MAX_NREQ   = 8;
  localparam int IDX_W      = 3;

  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 5'd0;

  // Sized for the largest supported requester count; callers zero-extend narrower grants.
  function automatic logic [IDX_W-1:0] ohToIdx(input logic [MAX_NREQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first set request at or above ptr, wrapping, wins.
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt
);

  localparam int PTR_W = $clog2(NREQ);

  always_comb begin
    logic             found;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = PTR_W'((int'(ptr) + off) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_read_arbiter.sv
// Round-robin sharing of the register-file read port; two-stage read with write bypass
// and a hardwired-zero register 0.
module rf_read_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ   = NREQ_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  output logic [NREQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]      rf_sel,
  input  logic [DATA_W-1:0]      rf_data,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [DATA_W-1:0]      wr_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_data
);

  localparam int PTR_W = $clog2(NREQ);
  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]    r_rrPtr;
  logic [ADDR_W-1:0]   r_rfSel;
  logic                r_s1Valid;
  logic [NREQ-1:0]     r_s1Owner;
  logic [NREQ-1:0]     r_rspValid;
  logic [DATA_W-1:0]   r_rspData;

  logic [NREQ-1:0]     w_gnt;
  logic [NREQ-1:0]     w_grant;
  logic                w_accept;
  logic [MAX_NREQ-1:0] w_gntWide;
  logic [IDX_W-1:0]    w_winIdx;
  logic [PTR_W-1:0]    w_nextPtr;
  logic [ADDR_W-1:0]   w_winAddr;
  logic                w_isZero;
  logic                w_bypassHit;
  logic [DATA_W-1:0]   w_readData;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rrArbiter (
    .req (req_valid),
    .ptr (r_rrPtr),
    .gnt (w_gnt)
  );

  // Grants are suppressed during reset so nothing is accepted into a stage being cleared.
  assign w_grant   = reset_n ? w_gnt : '0;
  assign w_accept  = |w_grant;
  assign req_ready = w_grant;

  always_comb begin
    w_gntWide             = '0;
    w_gntWide[NREQ-1:0]   = w_grant;
  end

  assign w_winIdx  = ohToIdx(w_gntWide);
  assign w_nextPtr = (w_winIdx == IDX_W'(NREQ - 1)) ? '0 : PTR_W'(w_winIdx + IDX_W'(1));

  always_comb begin
    w_winAddr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) w_winAddr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Bypass compares against the select already on the mux, so a write landing this cycle wins.
  assign w_isZero    = (r_rfSel == ZERO_SEL);
  assign w_bypassHit = wr_en && (wr_addr == r_rfSel);
  assign w_readData  = w_isZero    ? '0      :
                       w_bypassHit ? wr_data : rf_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rrPtr   <= '0;
      r_rfSel   <= '0;
      r_s1Valid <= 1'b0;
      r_s1Owner <= '0;
    end else if (w_accept) begin
      r_rrPtr   <= w_nextPtr;
      r_rfSel   <= w_winAddr;
      r_s1Valid <= 1'b1;
      r_s1Owner <= w_grant;
    end else begin
      r_s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rspValid <= '0;
      r_rspData  <= '0;
    end else if (r_s1Valid) begin
      r_rspValid <= r_s1Owner;
      r_rspData  <= w_readData;
    end else begin
      r_rspValid <= '0;
    end
  end

  assign rf_sel    = r_rfSel;
  assign rsp_valid = r_rspValid;
  assign rsp_data  = r_rspData;

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Scoreboard bench for rf_read_arbiter: the driver predicts grants and responses from a
// behavioural model; an independent monitor pops and compares responses on the falling edge.
module tb_rf_read_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic [ADDR_W-1:0]      rf_sel;
  logic [DATA_W-1:0]      rf_data;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;

  rf_read_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rf_sel    (rf_sel),
    .rf_data   (rf_data),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    int              cyc;
    logic [NREQ-1:0] owner;
    logic [DATA_W-1:0] data;
  } rsp_t;

  rsp_t              sbQ[$];
  int                cyc          = 0;
  int                nVectors     = 0;
  int                nMiscompares = 0;
  bit                checkEn      = 1'b0;
  logic [DATA_W-1:0] lastData     = '0;

  // Model state: pointer, current mux select and the single in-flight read.
  int                mPtr     = 0;
  int                mSel     = 0;
  bit                mS1Valid = 1'b0;
  logic [NREQ-1:0]   mS1Owner = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ*ADDR_W-1:0] packAddr(input int a0, input int a1, input int a2, input int a3);
    logic [NREQ*ADDR_W-1:0] v;
    v = {ADDR_W'(a3), ADDR_W'(a2), ADDR_W'(a1), ADDR_W'(a0)};
    return v;
  endfunction

  // One clock cycle: drive inputs, predict, check the combinational grant and the select.
  task automatic applyStimulus(input logic rstN, input logic [NREQ-1:0] valid,
                               input logic [NREQ*ADDR_W-1:0] addrs, input logic [DATA_W-1:0] rfD,
                               input logic wrE, input logic [ADDR_W-1:0] wrA,
                               input logic [DATA_W-1:0] wrD);
    logic [NREQ-1:0]   expGnt;
    logic [DATA_W-1:0] expData;
    rsp_t              item;
    int                win;
    @(posedge clock);
    cyc++;
    #1;
    reset_n   = rstN;
    req_valid = valid;
    req_addr  = addrs;
    rf_data   = rfD;
    wr_en     = wrE;
    wr_addr   = wrA;
    wr_data   = wrD;
    if (rstN && mS1Valid) begin
      if (mSel == 0) expData = '0;
      else if (wrE && int'(wrA) == mSel) expData = wrD;
      else expData = rfD;
      item.cyc   = cyc + 1;
      item.owner = mS1Owner;
      item.data  = expData;
      sbQ.push_back(item);
    end
    expGnt = '0;
    win    = -1;
    if (rstN) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mPtr + k) % NREQ;
        if (valid[idx]) begin
          win = idx;
          break;
        end
      end
    end
    if (win >= 0) expGnt[win] = 1'b1;
    #1;
    checkOutput("reqReady", 64'(req_ready), 64'(expGnt));
    if (checkEn) checkOutput("rfSel", 64'(rf_sel), 64'(mSel));
    if (!rstN) begin
      mPtr     = 0;
      mSel     = 0;
      mS1Valid = 1'b0;
    end else if (win >= 0) begin
      mPtr     = (win + 1) % NREQ;
      mSel     = int'(addrs[win*ADDR_W +: ADDR_W]);
      mS1Valid = 1'b1;
      mS1Owner = expGnt;
    end else begin
      mS1Valid = 1'b0;
    end
  endtask

  task automatic idleCycle(input logic [DATA_W-1:0] rfD, input logic wrE,
                           input logic [ADDR_W-1:0] wrA, input logic [DATA_W-1:0] wrD);
    applyStimulus(1'b1, '0, '0, rfD, wrE, wrA, wrD);
  endtask

  // Monitor: every falling edge either a predicted response is due or outputs must stay idle.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (checkEn) begin
        if (sbQ.size() > 0 && sbQ[0].cyc == cyc) begin
          e = sbQ.pop_front();
          checkOutput("rspValid", 64'(rsp_valid), 64'(e.owner));
          checkOutput("rspData", 64'(rsp_data), 64'(e.data));
          lastData = e.data;
        end else begin
          checkOutput("rspIdle", 64'(rsp_valid), 64'(0));
          checkOutput("rspHold", 64'(rsp_data), 64'(lastData));
        end
        if (reset_n == 1'b0) lastData = '0;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rf_data   = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;

    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0);
    checkEn = 1'b1;

    // Single request: requester 2 reads register 7.
    applyStimulus(1'b1, 4'b0100, packAddr(0, 0, 7, 0), $urandom, 1'b0, '0, '0);
    idleCycle(32'hDEADBEEF, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);

    // All requesters held from pointer 0.
    applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, 4'b1111, packAddr(i + 1, i + 9, i + 17, i + 23), $urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);

    // Register 0 reads as zero even with a write to it in flight.
    applyStimulus(1'b1, 4'b0010, packAddr(3, 0, 3, 3), $urandom, 1'b0, '0, '0);
    idleCycle(32'hFFFFFFFF, 1'b1, 5'd0, 32'h5);

    // Bypass hit then miss.
    applyStimulus(1'b1, 4'b0001, packAddr(9, 0, 0, 0), $urandom, 1'b0, '0, '0);
    idleCycle(32'hAAAA, 1'b1, 5'd9, 32'h1234);
    applyStimulus(1'b1, 4'b0001, packAddr(9, 0, 0, 0), $urandom, 1'b0, '0, '0);
    idleCycle(32'hAAAA, 1'b1, 5'd10, 32'h1234);
    idleCycle($urandom, 1'b0, '0, '0);

    // Reset while a read is in flight; then everyone requests.
    applyStimulus(1'b1, 4'b0100, packAddr(1, 2, 3, 4), $urandom, 1'b0, '0, '0);
    applyStimulus(1'b0, '0, '0, $urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    applyStimulus(1'b1, 4'b1111, packAddr(5, 6, 7, 8), $urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);

    // Idle gap between two requests.
    applyStimulus(1'b1, 4'b1000, packAddr(0, 0, 0, 12), $urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    idleCycle($urandom, 1'b0, '0, '0);
    applyStimulus(1'b1, 4'b0001, packAddr(13, 0, 0, 0), $urandom, 1'b0, '0, '0);
    for (int i = 0; i < 4; i++) idleCycle($urandom, 1'b0, '0, '0);

    // Randomized traffic with a narrow address range so bypass and zero cases recur.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 39) != 0),
                    NREQ'($urandom_range(0, 15)),
                    packAddr($urandom_range(0, 7), $urandom_range(0, 7),
                             $urandom_range(0, 7), $urandom_range(0, 31)),
                    $urandom, 1'($urandom_range(0, 1)),
                    ADDR_W'($urandom_range(0, 7)), $urandom);
    end

    for (int i = 0; i < 4; i++) idleCycle($urandom, 1'b0, '0, '0);
    checkOutput("scoreboardDrained", 64'(sbQ.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
